// File: rtl/bus_pkg.sv
// Shared definitions for the bus responder: IO page offsets, STATUS bit
// positions, default IO page base and the value returned for unmapped reads.
package bus_pkg;

    // Offset inside the IO page, taken from A[1:0].
    typedef enum logic [1:0] {
        OFF_TXDATA = 2'd0,
        OFF_STATUS = 2'd1,
        OFF_RXDATA = 2'd2,
        OFF_MASK   = 2'd3
    } io_off_e;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
    localparam logic [15:0] UNMAPPED_DATA   = 16'h0000;

    // STATUS register bit positions.
    localparam int ST_IRQ      = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;

    typedef struct packed {
        logic tx_full;
        logic tx_empty;
        logic rx_full;
        logic irq_pending;
    } status_t;

    // Places the status flags at their architectural bit positions.
    function automatic logic [15:0] pack_status(status_t s);
        logic [15:0] r;
        r              = '0;
        r[ST_TX_FULL]  = s.tx_full;
        r[ST_TX_EMPTY] = s.tx_empty;
        r[ST_RX_FULL]  = s.rx_full;
        r[ST_IRQ]      = s.irq_pending;
        return r;
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU address/data bus between the core (master) and the responder (slave).
//   A     address from CPU
//   DOut  CPU write data
//   WOut  CPU write strobe
//   DIn   registered read data to CPU
//   IRQ   registered level interrupt request to CPU
interface bus_responder_if;
    logic [15:0] A;
    logic [15:0] DOut;
    logic        WOut;
    logic [15:0] DIn;
    logic        IRQ;

    modport master (output A, DOut, WOut, input DIn, IRQ);
    modport slave  (input A, DOut, WOut, output DIn, IRQ);
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO feeding the serial transmitter.
//   CLK, RST   clock and synchronous active-high reset
//   push/push_data  enqueue request and byte (dropped when full unless a pop
//                   happens in the same cycle)
//   pop        dequeue request (ignored when empty)
//   head       byte at the front of the queue
//   full/empty/count  occupancy
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == (PW + 1)'(DEPTH));

    // A pop frees the head slot before the push lands, so a full FIFO still
    // accepts a byte when it is draining in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr];

    // NOTE: storage has no reset; pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (do_push && !RST)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped target on the CPU bus: internal word RAM plus a small IO page
// with a TX byte FIFO, an RX holding register, STATUS and an interrupt MASK.
//   CLK, RST   clock and synchronous active-high reset
//   bus        CPU bus (slave side): A, DOut, WOut in; DIn, IRQ out (registered)
//   TxData/TxValid/TxReady  byte stream toward the serial transmitter
//   RxData/RxValid/RxReady  byte stream from the serial receiver
// Reads have one cycle latency and no strobe: DIn follows A every cycle.
module bus_responder
    import bus_pkg::*;
#(
    parameter int          RAM_AW   = 8,
    parameter int          TX_DEPTH = 4,
    parameter logic [15:0] IO_BASE  = IO_BASE_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    bus_responder_if.slave   bus,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxReady,
    input  logic [7:0]       RxData,
    input  logic             RxValid,
    output logic             RxReady
);
    localparam int RAM_WORDS = 2 ** RAM_AW;
    localparam int CW        = $clog2(TX_DEPTH) + 1;

    logic [15:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;

    logic        in_ram;
    logic        in_io;
    io_off_e     off;

    logic        w_prev;
    logic [15:0] a_prev;
    logic        wr_edge;

    logic [1:0]  mask;
    logic        rx_full;
    logic [7:0]  rx_byte;
    logic        rx_load;
    logic        rx_pop;

    logic        tx_push;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic [CW-1:0] tx_count;

    status_t     status;
    logic        irq_pending;
    logic [15:0] rd_data;

    // Address decode. RAM wins if a wide RAM ever overlaps the IO page.
    assign in_ram  = (17'(bus.A) < 17'(RAM_WORDS));
    assign in_io   = !in_ram && (bus.A[15:8] == IO_BASE[15:8]);
    assign off     = io_off_e'(bus.A[1:0]);
    assign ram_idx = bus.A[RAM_AW-1:0];

    // The microcode holds WOut for a whole step; only its rising edge writes.
    assign wr_edge = bus.WOut && !w_prev;

    assign tx_push = wr_edge && in_io && (off == OFF_TXDATA);
    assign tx_pop  = TxValid && TxReady;

    // The RX pop is a read side effect, so it fires only on the first cycle
    // the address lands on RXDATA; holding the address does not pop again.
    assign rx_pop  = in_io && (off == OFF_RXDATA) && (bus.A != a_prev) && rx_full;
    assign rx_load = RxValid && RxReady;
    assign RxReady = !rx_full;

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (tx_push),
        .push_data (bus.DOut[7:0]),
        .pop       (tx_pop),
        .head      (TxData),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign TxValid = (tx_count != '0);

    assign irq_pending        = (rx_full & mask[0]) | (tx_empty & mask[1]);
    assign status.tx_full     = tx_full;
    assign status.tx_empty    = tx_empty;
    assign status.rx_full     = rx_full;
    assign status.irq_pending = irq_pending;

    // NOTE: every output of a combinational block gets a default first so no
    // latch is inferred on an unlisted path.
    always_comb begin
        rd_data = UNMAPPED_DATA;
        if (in_ram) begin
            rd_data = ram[ram_idx];
        end else if (in_io) begin
            case (off)
                OFF_TXDATA: rd_data = 16'h0000;
                OFF_STATUS: rd_data = pack_status(status);
                OFF_RXDATA: rd_data = {8'h00, rx_full ? rx_byte : 8'h00};
                OFF_MASK:   rd_data = {14'b0, mask};
                default:    rd_data = UNMAPPED_DATA;
            endcase
        end
    end

    // NOTE: the RAM array is deliberately left out of reset; clearing it
    // would turn it into a register file.
    always_ff @(posedge CLK) begin
        if (!RST && wr_edge && in_ram)
            ram[ram_idx] <= bus.DOut;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.DIn <= '0;
            bus.IRQ <= 1'b0;
            w_prev  <= 1'b0;
            a_prev  <= '0;
            mask    <= '0;
            rx_full <= 1'b0;
            rx_byte <= '0;
        end else begin
            bus.DIn <= rd_data;
            bus.IRQ <= irq_pending;
            w_prev  <= bus.WOut;
            a_prev  <= bus.A;

            if (wr_edge && in_io && (off == OFF_MASK))
                mask <= bus.DOut[1:0];

            // A load in the same cycle as a pop replaces the byte the CPU
            // just took, so the register stays full.
            if (rx_load) begin
                rx_byte <= RxData;
                rx_full <= 1'b1;
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder with a decoupled scoreboard: stimulus
// queues expected values, monitors compare when the DUT presents them.
module tb_bus_responder;

    typedef enum {SIG_DIN, SIG_IRQ, SIG_TXVALID, SIG_RXREADY} sig_e;

    typedef struct {
        sig_e        sig;
        logic [15:0] val;
        int          due;
        string       name;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxReady;

    bus_responder_if bus ();

    bus_responder #(
        .RAM_AW   (8),
        .TX_DEPTH (4),
        .IO_BASE  (16'hFF00)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .TxData  (TxData),
        .TxValid (TxValid),
        .TxReady (TxReady),
        .RxData  (RxData),
        .RxValid (RxValid),
        .RxReady (RxReady)
    );

    always #5 CLK = ~CLK;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       exp_q[$];
    logic [7:0] tx_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Queue an expectation for the value seen at the falling edge d cycles on.
    task automatic want(input sig_e s, input logic [15:0] v, input int d, input string n);
        exp_t e;
        e.sig  = s;
        e.val  = v;
        e.due  = cyc + d;
        e.name = n;
        exp_q.push_back(e);
    endtask

    // Monitor: signal expectations and the TX byte stream.
    always @(negedge CLK) begin
        exp_t        e;
        logic [15:0] act;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            case (e.sig)
                SIG_DIN:     act = bus.DIn;
                SIG_IRQ:     act = {15'b0, bus.IRQ};
                SIG_TXVALID: act = {15'b0, TxValid};
                default:     act = {15'b0, RxReady};
            endcase
            if (e.due < cyc)
                check({e.name, "_late"}, 16'(cyc), 16'(e.due));
            else
                check(e.name, act, e.val);
        end
        if (!RST && TxValid && TxReady) begin
            if (tx_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: emitted %h, required no byte", TxData);
            end else begin
                check("tx_data", {8'h00, TxData}, {8'h00, tx_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string n);
        bus.A = a;
        want(SIG_DIN, e, 1, n);
        step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.A    = a;
        bus.DOut = d;
        bus.WOut = 1'b1;
        step();
        bus.WOut = 1'b0;
        step();
    endtask

    initial begin
        RST      = 1'b1;
        bus.A    = 16'h8000;
        bus.DOut = 16'h0000;
        bus.WOut = 1'b0;
        TxReady  = 1'b0;
        RxData   = 8'h00;
        RxValid  = 1'b0;
        step();
        step();
        RST = 1'b0;

        // Reset state.
        want(SIG_DIN,     16'h0000, 0, "rst_din");
        want(SIG_IRQ,     16'h0000, 0, "rst_irq");
        want(SIG_TXVALID, 16'h0000, 0, "rst_txvalid");
        want(SIG_RXREADY, 16'h0001, 0, "rst_rxready");
        rd(16'hFF01, 16'h0004, "rst_status");
        rd(16'hFF03, 16'h0000, "rst_mask");

        // RAM: a held strobe writes once, even if the data changes under it.
        bus.A    = 16'h0012;
        bus.DOut = 16'hBEEF;
        bus.WOut = 1'b1;
        step();
        bus.DOut = 16'hDEAD;
        step();
        step();
        bus.WOut = 1'b0;
        rd(16'h0012, 16'hBEEF, "ram_held_write");
        rd(16'h8000, 16'h0000, "unmapped_read");
        wr(16'h0000, 16'h5555);
        wr(16'h00FF, 16'h1234);
        wr(16'h0100, 16'hAAAA);
        rd(16'h0000, 16'h5555, "ram_word0_no_alias");
        rd(16'h00FF, 16'h1234, "ram_top_word");
        rd(16'h0100, 16'h0000, "ram_end_unmapped");

        // TX FIFO: fill, overflow drop, then drain with a push while full.
        TxReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4)
                tx_q.push_back(8'(8'h11 + i));
            wr(16'hFF00, 16'(8'h11 + i));
        end
        want(SIG_TXVALID, 16'h0001, 0, "tx_valid_full");
        rd(16'hFF01, 16'h0008, "status_tx_full");
        rd(16'hFF00, 16'h0000, "txdata_reads_zero");
        tx_q.push_back(8'h16);
        bus.A    = 16'hFF00;
        bus.DOut = 16'h0016;
        bus.WOut = 1'b1;
        TxReady  = 1'b1;
        step();
        bus.WOut = 1'b0;
        repeat (6) step();
        want(SIG_TXVALID, 16'h0000, 0, "tx_drained");
        // Push into an empty FIFO while the transmitter is ready.
        tx_q.push_back(8'h21);
        wr(16'hFF00, 16'h0021);
        want(SIG_TXVALID, 16'h0000, 0, "tx_empty_again");
        rd(16'hFF01, 16'h0004, "status_tx_empty");
        TxReady = 1'b0;

        // RX register with RX-full interrupt enabled.
        wr(16'hFF03, 16'h0001);
        rd(16'hFF03, 16'h0001, "mask_readback");
        bus.A   = 16'hFF01;
        RxData  = 8'h5A;
        RxValid = 1'b1;
        want(SIG_DIN, 16'h0004, 1, "status_before_rx");
        step();
        RxValid = 1'b0;
        want(SIG_RXREADY, 16'h0000, 0, "rx_ready_low");
        want(SIG_IRQ,     16'h0000, 0, "irq_lags_source");
        want(SIG_IRQ,     16'h0001, 1, "irq_rx_full");
        want(SIG_DIN,     16'h0007, 1, "status_rx_full");
        step();
        bus.A = 16'hFF02;
        want(SIG_DIN, 16'h005A, 1, "rx_pop_data");
        want(SIG_IRQ, 16'h0001, 1, "irq_before_pop_seen");
        step();
        want(SIG_DIN, 16'h0000, 1, "rx_hold_no_repop1");
        want(SIG_IRQ, 16'h0000, 1, "irq_falls");
        step();
        want(SIG_DIN, 16'h0000, 1, "rx_hold_no_repop2");
        step();
        want(SIG_RXREADY, 16'h0001, 0, "rx_ready_after_pop");
        rd(16'hFF01, 16'h0004, "status_after_pop");
        rd(16'hFF02, 16'h0000, "rx_empty_reread");

        // Pop while the receiver is offering the next byte.
        bus.A   = 16'hFF01;
        RxData  = 8'h33;
        RxValid = 1'b1;
        step();
        bus.A   = 16'hFF02;
        RxData  = 8'h44;
        want(SIG_DIN, 16'h0033, 1, "rx_pop_old_byte");
        step();
        step();
        RxValid = 1'b0;
        rd(16'hFF01, 16'h0007, "status_new_byte_held");
        rd(16'hFF02, 16'h0044, "rx_new_byte");

        // Reset right after a TX push loses the byte and clears the mask.
        wr(16'hFF03, 16'h0002);
        want(SIG_IRQ, 16'h0001, 0, "irq_tx_empty");
        TxReady  = 1'b0;
        bus.A    = 16'hFF00;
        bus.DOut = 16'h0077;
        bus.WOut = 1'b1;
        step();
        bus.WOut = 1'b0;
        RST      = 1'b1;
        want(SIG_TXVALID, 16'h0001, 0, "tx_push_before_rst");
        step();
        RST = 1'b0;
        want(SIG_TXVALID, 16'h0000, 0, "tx_valid_after_rst");
        want(SIG_IRQ,     16'h0000, 0, "irq_at_rst");
        want(SIG_IRQ,     16'h0000, 1, "irq_after_rst");
        rd(16'hFF03, 16'h0000, "mask_after_rst");
        rd(16'hFF01, 16'h0004, "status_after_rst");
        TxReady = 1'b1;
        repeat (4) step();
        TxReady = 1'b0;

        repeat (3) step();
        check("expect_queue_drained", 16'(exp_q.size()), 16'h0000);
        check("tx_queue_drained", 16'(tx_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
